// File: rtl/grb_pkg.sv
// Shared constants and FSM state encoding for the GRB frame builder.
// The optional dimming feature is enabled by defining GRB_DIM_EN.
package grb_pkg;

    localparam int NUM_LEDS = 5;
    localparam int CH_W     = 8;
    localparam int LED_W    = 24;
    localparam int SEQ_W    = NUM_LEDS * LED_W;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

endpackage

// File: rtl/grb_pack.sv
// Transfer-time conditioning of one GRB word; with GRB_DIM_EN defined each
// channel is logically right-shifted by dim, otherwise the word passes through.
module grb_pack #(
    parameter int CH_W = grb_pkg::CH_W
) (
    input  logic [3*CH_W-1:0] grb_in,
`ifdef GRB_DIM_EN
    input  logic [1:0]        dim,
`endif
    output logic [3*CH_W-1:0] grb_out
);

`ifdef GRB_DIM_EN
    always_comb begin
        grb_out = {grb_in[3*CH_W-1 -: CH_W] >> dim,
                   grb_in[2*CH_W-1 -: CH_W] >> dim,
                   grb_in[CH_W-1   -: CH_W] >> dim};
    end
`else
    assign grb_out = grb_in;
`endif

endmodule

// File: rtl/grb_frame_builder.sv
// Double-buffered LED frame store: writes land in a shadow buffer and are
// published to the active frame only at a frame boundary (GRB_DIM_EN adds dim).
module grb_frame_builder #(
    parameter int NUM_LEDS = grb_pkg::NUM_LEDS,
    parameter int CH_W     = grb_pkg::CH_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [2:0]                 wr_idx,
    input  logic [CH_W-1:0]            wr_r,
    input  logic [CH_W-1:0]            wr_g,
    input  logic [CH_W-1:0]            wr_b,
    input  logic                       clr,
    input  logic                       commit,
    input  logic                       cycle,
`ifdef GRB_DIM_EN
    input  logic [1:0]                 dim,
`endif
    output logic [NUM_LEDS*3*CH_W-1:0] grb_seq,
    output logic                       pending,
    output logic                       wr_err,
    output logic [7:0]                 frame_cnt
);

    localparam int LED_BITS = 3 * CH_W;

    logic [1:0]          state_q, state_d;
    logic [LED_BITS-1:0] shadow_q [NUM_LEDS];
    logic [LED_BITS-1:0] shadow_d [NUM_LEDS];
    logic [LED_BITS-1:0] active_q [NUM_LEDS];
    logic [LED_BITS-1:0] active_d [NUM_LEDS];
    logic [LED_BITS-1:0] packed_w [NUM_LEDS];
    logic                wr_err_q, wr_err_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                idx_ok;
    logic                transfer;

    assign idx_ok   = int'(wr_idx) < NUM_LEDS;
    assign transfer = (state_q == grb_pkg::ST_PENDING) && cycle;

    // LED0 occupies the most significant word of the frame.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        grb_pack #(.CH_W(CH_W)) u_pack (
            .grb_in  (shadow_q[i]),
`ifdef GRB_DIM_EN
            .dim     (dim),
`endif
            .grb_out (packed_w[i])
        );
        assign grb_seq[(NUM_LEDS-1-i)*LED_BITS +: LED_BITS] = active_q[i];
    end

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            grb_pkg::ST_EMPTY,
            grb_pkg::ST_IDLE:    if (commit) state_d = grb_pkg::ST_PENDING;
            grb_pkg::ST_PENDING: if (cycle && !commit) state_d = grb_pkg::ST_IDLE;
            default:             state_d = grb_pkg::ST_EMPTY;
        endcase
    end

    // Transfers read shadow_q, so a write in the same cycle only reaches the shadow.
    always_comb begin
        shadow_d    = shadow_q;
        active_d    = active_q;
        frame_cnt_d = frame_cnt_q;
        wr_err_d    = wr_en && !idx_ok;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (clr) begin
                shadow_d[i] = '0;
            end else if (wr_en && (int'(wr_idx) == i)) begin
                shadow_d[i] = {wr_g, wr_r, wr_b};
            end
        end
        if (transfer) begin
            active_d    = packed_w;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    // NOTE: both buffers are reset because the frame must read zero until the first transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= grb_pkg::ST_EMPTY;
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            wr_err_q    <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            wr_err_q    <= wr_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pending   = (state_q == grb_pkg::ST_PENDING);
    assign wr_err    = wr_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/grb_frame_builder.md
GRB_FRAME_BUILDER -- requirements
Module: grb_frame_builder

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 5, giving the number of LEDs per frame.
REQ-002 SHALL have parameter CH_W, default 8, giving the bits per colour channel.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port wr_en, input, 1 bit: write one LED colour into the shadow buffer.
REQ-006 SHALL have port wr_idx, input, 3 bits: LED index for the write.
REQ-007 SHALL have ports wr_r, wr_g and wr_b, each input, CH_W bits: the RGB colour for the write.
REQ-008 SHALL have port clr, input, 1 bit: zero the whole shadow buffer.
REQ-009 SHALL have port commit, input, 1 bit: request that the shadow buffer be published.
REQ-010 SHALL have port cycle, input, 1 bit: one-cycle pulse from the send state machine marking a frame boundary.
REQ-011 SHALL have port grb_seq, output, NUM_LEDS*3*CH_W bits (120 at defaults): the active frame, feeding the shift-register load.
REQ-012 SHALL have port pending, output, 1 bit: a commit is waiting for a frame boundary.
REQ-013 SHALL have port wr_err, output, 1 bit: one-cycle pulse when a write has an out-of-range index.
REQ-014 SHALL have port frame_cnt, output, 8 bits: count of completed transfers.

Function
REQ-015 SHALL hold a shadow buffer and an active buffer, each NUM_LEDS x 24 bits.
REQ-016 SHALL, when wr_en=1 and wr_idx<NUM_LEDS, write {wr_g,wr_r,wr_b} into shadow entry wr_idx on the next edge; this reorders RGB to GRB.
REQ-017 SHALL, when wr_en=1 and wr_idx>=NUM_LEDS, leave the shadow buffer unchanged and assert wr_err for exactly one cycle.
REQ-018 SHALL, on clr=1, zero every shadow entry; if clr and wr_en are asserted in the same cycle, clr wins.
REQ-019 SHALL map grb_seq from the active buffer with LED0 at bits [119:96] in order G,R,B, MSB first, and LED4 at [23:0].
REQ-020 SHALL implement states EMPTY, IDLE and PENDING.
  - EMPTY: held after reset until the first transfer; grb_seq=0 and cycle is ignored.
  - commit=1 moves EMPTY or IDLE to PENDING.
  - In PENDING, cycle=1 performs a transfer (shadow copied to active) and moves to IDLE.
REQ-021 SHALL, on commit and cycle in the same cycle while in PENDING, perform the transfer and remain in PENDING.
REQ-022 SHALL, on commit and cycle in the same cycle while in EMPTY or IDLE, perform no transfer and enter PENDING.
REQ-023 SHALL, on a write in the same cycle as a transfer, copy the pre-write shadow contents; the write lands in the shadow buffer only.
REQ-024 SHALL update grb_seq one cycle after the transfer edge (registered output).
REQ-025 SHALL drive pending=1 exactly when the state is PENDING.
REQ-026 SHALL increment frame_cnt by 1 per transfer, wrapping from 255 to 0.
REQ-027 SHALL leave grb_seq stable at all times other than a transfer edge, so there is no tearing mid-transmission.

Reset
REQ-028 SHALL, while reset=0, asynchronously set state=EMPTY, both buffers=0, grb_seq=0, pending=0, wr_err=0 and frame_cnt=0.
REQ-029 SHALL, on reset asserted mid-PENDING, discard the pending commit, and SHALL require a new commit after reset release.

Configuration
REQ-030 SHALL, with macro GRB_DIM_EN defined, add input dim (2 bits), and each channel copied at a transfer SHALL be logically right-shifted by dim; dim=0 passes values unchanged.
REQ-031 SHALL, without GRB_DIM_EN, have no dim port, and transfers SHALL copy values unchanged.

Structure
REQ-032 SHALL take NUM_LEDS, CH_W, LED_W=24, SEQ_W=NUM_LEDS*LED_W and the state encoding from shared package grb_pkg.
REQ-033 SHALL instantiate sub-module grb_pack, one per LED, which applies the optional dim to one 24-bit GRB word at transfer.

Verification
REQ-034 SHALL cover: reset, write LED0 with RGB=(0x11,0x22,0x33), commit, cycle -> grb_seq[119:96]=0x221133, frame_cnt=1, pending=0.
REQ-035 SHALL cover: cycle pulses in EMPTY with no commit -> grb_seq stays 0 and frame_cnt stays 0.
REQ-036 SHALL cover: wr_idx=5 with wr_en=1 -> wr_err high for 1 cycle and shadow unchanged (verified by commit+cycle).
REQ-037 SHALL cover: in PENDING, commit+cycle in the same cycle -> one transfer and pending stays 1; the next cycle pulse performs a second transfer, so frame_cnt advances by 2.
REQ-038 SHALL cover: write during the transfer cycle -> active frame holds the old value and the following transfer shows the new value; also 256 transfers -> frame_cnt returns to 0.
REQ-039 SHALL cover, with GRB_DIM_EN and dim=2: LED0 RGB=(0x80,0xFF,0x04) -> grb_seq[119:96]=0x3F2001.
